// File: rtl/id_issue_arbiter.sv
// Round-robin arbiter that shares the single decode-to-issue slot between the fetch path
// (source 0) and an injection path (source 1). It supports atomic source-1 bursts guarded
// by a lock watchdog.
module id_issue_arbiter #(
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned LockTimeout = 16,
  parameter int unsigned CntWidth    = $clog2(LockTimeout + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 src0_valid_i,
  input  logic [DataWidth-1:0] src0_data_i,
  output logic                 src0_ready_o,
  input  logic                 src1_valid_i,
  input  logic [DataWidth-1:0] src1_data_i,
  input  logic                 src1_last_i,
  output logic                 src1_ready_o,
  output logic                 issue_valid_o,
  output logic [DataWidth-1:0] issue_data_o,
  output logic                 issue_src_o,
  input  logic                 issue_ack_i,
  output logic                 locked_o,
  output logic                 lock_timeout_o
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  lock_state_e          state_q;
  logic                 valid_q;
  logic [DataWidth-1:0] data_q;
  logic                 src_q;
  logic                 last_q;
  logic                 timeout_q;
  logic [CntWidth-1:0]  cnt_q;

  logic space;
  logic grant_ok;
  logic gnt0;
  logic gnt1;
  logic release_gnt;
  logic timeout_hit;

  // While locked, only source 1 may take the slot. On a tie, the source that did not win last time gets the grant.
  always_comb begin
    space       = !valid_q || issue_ack_i;
    grant_ok    = space && !flush_i;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    if (grant_ok) begin
      if (state_q == LOCKED) begin
        gnt1 = src1_valid_i;
      end else if (src0_valid_i && src1_valid_i) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = src0_valid_i;
        gnt1 = src1_valid_i;
      end
    end
    release_gnt = gnt1 && src1_last_i;
    timeout_hit = (state_q == LOCKED) && (cnt_q == CntWidth'(LockTimeout - 1)) && !release_gnt;
  end

  assign src0_ready_o   = gnt0;
  assign src1_ready_o   = gnt1;
  assign issue_valid_o  = valid_q;
  assign issue_data_o   = data_q;
  assign issue_src_o    = src_q;
  assign locked_o       = (state_q == LOCKED);
  assign lock_timeout_o = timeout_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= UNLOCKED;
      valid_q   <= 1'b0;
      data_q    <= '0;
      src_q     <= 1'b0;
      last_q    <= 1'b1;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      timeout_q <= 1'b0;

      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (gnt0 || gnt1) begin
        valid_q <= 1'b1;
        data_q  <= gnt1 ? src1_data_i : src0_data_i;
        src_q   <= gnt1;
        last_q  <= gnt1;
      end else if (issue_ack_i) begin
        valid_q <= 1'b0;
      end

      // A flush beats everything. If a last-beat grant and a timeout land in the same cycle, the grant takes precedence.
      if (flush_i) begin
        state_q <= UNLOCKED;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          UNLOCKED: begin
            if (gnt1 && !src1_last_i) begin
              state_q <= LOCKED;
              cnt_q   <= '0;
            end
          end
          LOCKED: begin
            if (release_gnt) begin
              state_q <= UNLOCKED;
              cnt_q   <= '0;
            end else if (timeout_hit) begin
              state_q   <= UNLOCKED;
              cnt_q     <= '0;
              timeout_q <= 1'b1;
            end else if (cnt_q != CntWidth'(LockTimeout)) begin
              cnt_q <= cnt_q + CntWidth'(1);
            end
          end
          default: begin
            state_q <= UNLOCKED;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_id_issue_arbiter.sv
// Directed bench for id_issue_arbiter. It covers fairness, bursts, backpressure, the
// lock watchdog, flush, and reset while a burst is in progress.
module tb_id_issue_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        src0_valid_i = 1'b0;
  logic [63:0] src0_data_i = '0;
  logic        src0_ready_o;
  logic        src1_valid_i = 1'b0;
  logic [63:0] src1_data_i = '0;
  logic        src1_last_i = 1'b0;
  logic        src1_ready_o;
  logic        issue_valid_o;
  logic [63:0] issue_data_o;
  logic        issue_src_o;
  logic        issue_ack_i = 1'b0;
  logic        locked_o;
  logic        lock_timeout_o;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [63:0] A0 = 64'h0000_0000_0000_0A00;
  localparam logic [63:0] A1 = 64'h0000_0000_0000_0A01;
  localparam logic [63:0] A2 = 64'h0000_0000_0000_0A02;
  localparam logic [63:0] B0 = 64'h0000_0000_0000_0B00;
  localparam logic [63:0] B1 = 64'h0000_0000_0000_0B01;
  localparam logic [63:0] B2 = 64'h0000_0000_0000_0B02;
  localparam logic [63:0] B3 = 64'h0000_0000_0000_0B03;
  localparam logic [63:0] B4 = 64'h0000_0000_0000_0B04;
  localparam logic [63:0] B5 = 64'h0000_0000_0000_0B05;
  localparam logic [63:0] B6 = 64'h0000_0000_0000_0B06;
  localparam logic [63:0] B7 = 64'h0000_0000_0000_0B07;
  localparam logic [63:0] B8 = 64'h0000_0000_0000_0B08;

  id_issue_arbiter #(.DataWidth(64), .LockTimeout(16)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .src0_valid_i   (src0_valid_i),
    .src0_data_i    (src0_data_i),
    .src0_ready_o   (src0_ready_o),
    .src1_valid_i   (src1_valid_i),
    .src1_data_i    (src1_data_i),
    .src1_last_i    (src1_last_i),
    .src1_ready_o   (src1_ready_o),
    .issue_valid_o  (issue_valid_o),
    .issue_data_o   (issue_data_o),
    .issue_src_o    (issue_src_o),
    .issue_ack_i    (issue_ack_i),
    .locked_o       (locked_o),
    .lock_timeout_o (lock_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change on the falling edge, and checks run 1ns later, well away from the rising edge.
  task automatic apply_stimulus(input logic f, input logic v0, input logic [63:0] d0,
                                input logic v1, input logic [63:0] d1, input logic l1,
                                input logic ack);
    @(negedge clk_i);
    flush_i      = f;
    src0_valid_i = v0;
    src0_data_i  = d0;
    src1_valid_i = v1;
    src1_data_i  = d1;
    src1_last_i  = l1;
    issue_ack_i  = ack;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset state
    #2;
    check_output("rst_valid", issue_valid_o, 0);
    check_output("rst_data", issue_data_o, 0);
    check_output("rst_src", issue_src_o, 0);
    check_output("rst_locked", locked_o, 0);
    check_output("rst_timeout", lock_timeout_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Fairness: when both sources are valid and the slot is acknowledged every cycle, the grant alternates 0,1,0,1,0.
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(0, 1, A0, 1, B0, 1, 1);
      check_output($sformatf("tie%0d_r0", i), src0_ready_o, (i % 2) == 0);
      check_output($sformatf("tie%0d_r1", i), src1_ready_o, (i % 2) == 1);
      if (i > 0) begin
        check_output($sformatf("tie%0d_src", i), issue_src_o, (i - 1) % 2);
        check_output($sformatf("tie%0d_vld", i), issue_valid_o, 1);
      end
    end

    // Burst of three beats from source 1 while source 0 stays valid.
    apply_stimulus(0, 1, A0, 1, B1, 0, 1);
    check_output("b1_r1", src1_ready_o, 1);
    check_output("b1_r0", src0_ready_o, 0);
    check_output("b1_lock", locked_o, 0);
    check_output("b1_data", issue_data_o, A0);
    apply_stimulus(0, 1, A0, 1, B2, 0, 1);
    check_output("b2_lock", locked_o, 1);
    check_output("b2_r0", src0_ready_o, 0);
    check_output("b2_r1", src1_ready_o, 1);
    check_output("b2_data", issue_data_o, B1);
    apply_stimulus(0, 1, A0, 1, B3, 1, 1);
    check_output("b3_lock", locked_o, 1);
    check_output("b3_r0", src0_ready_o, 0);
    check_output("b3_r1", src1_ready_o, 1);
    check_output("b3_data", issue_data_o, B2);
    apply_stimulus(0, 1, A0, 0, B3, 0, 1);
    check_output("bpost_lock", locked_o, 0);
    check_output("bpost_r0", src0_ready_o, 1);
    check_output("bpost_data", issue_data_o, B3);
    check_output("bpost_src", issue_src_o, 1);

    // Backpressure: the slot holds A0 and no ack arrives for four cycles.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(0, 1, A1, 1, B4, 1, 0);
      check_output($sformatf("bp%0d_r0", i), src0_ready_o, 0);
      check_output($sformatf("bp%0d_r1", i), src1_ready_o, 0);
      check_output($sformatf("bp%0d_data", i), issue_data_o, A0);
    end
    apply_stimulus(0, 1, A1, 1, B4, 1, 1);
    check_output("bpack_r1", src1_ready_o, 1);
    check_output("bpack_r0", src0_ready_o, 0);
    apply_stimulus(0, 0, A1, 0, B4, 0, 1);
    check_output("refill_data", issue_data_o, B4);
    check_output("refill_vld", issue_valid_o, 1);
    apply_stimulus(0, 0, A1, 0, B4, 0, 0);
    check_output("drain_vld", issue_valid_o, 0);
    check_output("drain_hold", issue_data_o, B4);

    // Watchdog: the lock is entered and source 1 then stalls, so the lock must release after 16 locked cycles.
    apply_stimulus(0, 0, A2, 1, B5, 0, 1);
    check_output("to_enter_r1", src1_ready_o, 1);
    for (int k = 1; k <= 16; k++) begin
      apply_stimulus(0, 1, A2, 0, B5, 0, 1);
      check_output($sformatf("to%0d_lock", k), locked_o, 1);
      check_output($sformatf("to%0d_r0", k), src0_ready_o, 0);
      check_output($sformatf("to%0d_pulse", k), lock_timeout_o, 0);
    end
    apply_stimulus(0, 1, A2, 0, B5, 0, 1);
    check_output("to_rel_lock", locked_o, 0);
    check_output("to_rel_pulse", lock_timeout_o, 1);
    check_output("to_rel_r0", src0_ready_o, 1);
    apply_stimulus(0, 0, A2, 0, B5, 0, 0);
    check_output("to_after_pulse", lock_timeout_o, 0);
    check_output("to_after_data", issue_data_o, A2);
    check_output("to_after_src", issue_src_o, 0);

    // A last beat that arrives in the timeout cycle releases the lock normally, with no timeout pulse.
    apply_stimulus(0, 0, A2, 1, B6, 0, 1);
    check_output("tl_enter_r1", src1_ready_o, 1);
    for (int k = 1; k <= 15; k++) begin
      apply_stimulus(0, 0, A2, 0, B6, 0, 1);
    end
    apply_stimulus(0, 0, A2, 1, B7, 1, 1);
    check_output("tl_lock16", locked_o, 1);
    check_output("tl_r1", src1_ready_o, 1);
    apply_stimulus(0, 0, A2, 0, B7, 0, 0);
    check_output("tl_rel_lock", locked_o, 0);
    check_output("tl_rel_pulse", lock_timeout_o, 0);
    check_output("tl_rel_data", issue_data_o, B7);

    // Flush while the slot is valid, the lock is held and source 1 is valid.
    apply_stimulus(0, 0, A1, 1, B6, 0, 1);
    check_output("fl_enter_r1", src1_ready_o, 1);
    apply_stimulus(1, 1, A1, 1, B7, 0, 0);
    check_output("fl_lock_before", locked_o, 1);
    check_output("fl_r0", src0_ready_o, 0);
    check_output("fl_r1", src1_ready_o, 0);
    apply_stimulus(0, 1, A1, 1, B7, 1, 0);
    check_output("fl_vld", issue_valid_o, 0);
    check_output("fl_lock", locked_o, 0);
    check_output("fl_tie_r0", src0_ready_o, 1);
    check_output("fl_tie_r1", src1_ready_o, 0);

    // Reset asserted while a burst is in progress.
    apply_stimulus(0, 0, A1, 1, B8, 0, 1);
    check_output("mr_b1_r1", src1_ready_o, 1);
    apply_stimulus(0, 0, A1, 0, B8, 0, 0);
    check_output("mr_lock", locked_o, 1);
    check_output("mr_data", issue_data_o, B8);
    #1 rst_ni = 1'b0;
    #1;
    check_output("mr_rst_vld", issue_valid_o, 0);
    check_output("mr_rst_data", issue_data_o, 0);
    check_output("mr_rst_src", issue_src_o, 0);
    check_output("mr_rst_lock", locked_o, 0);
    check_output("mr_rst_pulse", lock_timeout_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    apply_stimulus(0, 1, A2, 1, B8, 1, 0);
    check_output("mr_tie_r0", src0_ready_o, 1);
    check_output("mr_tie_r1", src1_ready_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_issue_arbiter.md
Name: id_issue_arbiter

Overview:
- Shares the single decode-to-issue pipeline slot between two decoded-instruction sources. Source 0 is the normal fetch/decode path; source 1 is an injection path, such as a macro-op or replay sequencer.
- Holds one registered issue entry with valid/ack semantics identical to the ID/issue register.
- Arbitrates round-robin, supports atomic source-1 bursts with a lock watchdog, and drops the slot on flush.

Parameters:
- DataWidth, 64, width of the opaque decoded-entry payload, carried unmodified.
- LockTimeout, 16, maximum cycles a source-1 burst lock may persist before forced release. Must be >= 2.
- CntWidth, $clog2(LockTimeout+1), width of the lock-duration counter.

Ports:
- clk_i  in  1  subsystem clock
- rst_ni  in  1  asynchronous reset, active low
- flush_i  in  1  controller flush; drops the held entry and the burst lock
- src0_valid_i  in  1  source 0 has a decoded entry
- src0_data_i  in  DataWidth  source 0 entry
- src0_ready_o  out  1  source 0 entry accepted this cycle
- src1_valid_i  in  1  source 1 has a decoded entry
- src1_data_i  in  DataWidth  source 1 entry
- src1_last_i  in  1  entry is the final beat of a source-1 burst; a single beat has last=1
- src1_ready_o  out  1  source 1 entry accepted this cycle
- issue_valid_o  out  1  held entry valid
- issue_data_o  out  DataWidth  held entry
- issue_src_o  out  1  source of the held entry (0/1)
- issue_ack_i  in  1  issue stage consumes the held entry
- locked_o  out  1  source-1 burst lock active
- lock_timeout_o  out  1  one-cycle pulse on forced lock release

Behaviour:
- Clock and reset:
  - One clock, clk_i; reset rst_ni is asynchronous, active low.
  - Reset values: issue_valid_o=0, issue_data_o=0, issue_src_o=0, locked_o=0, lock_timeout_o=0, lock counter=0.
  - Round-robin pointer last_q resets to 1, so source 0 wins the first tie.
- Slot availability: space = !valid_q || issue_ack_i. At most one ready per cycle, and ready is combinational.
- Grant when space && !flush_i:
  - locked_q=1: only source 1 is eligible; src0_ready_o=0.
  - Unlocked, one valid source: that source wins.
  - Unlocked, both valid: the source != last_q wins.
- On a grant:
  - Load valid_q=1, data_q = winner data, src_q = winner id, last_q = winner id.
  - Latency: entry appears on issue_* the cycle after the ready/valid handshake.
- Ack without a new grant: valid_q clears and data_q is held. Ack together with a grant: back-to-back refill, no bubble.
- Lock FSM, states UNLOCKED/LOCKED:
  - UNLOCKED -> LOCKED: source-1 grant with src1_last_i=0.
  - LOCKED -> UNLOCKED: source-1 grant with src1_last_i=1, or flush_i, or timeout.
  - A source-1 grant with last=1 while UNLOCKED stays UNLOCKED.
- Lock counter:
  - Clears on entry to LOCKED and increments each LOCKED cycle, saturating.
  - When it equals LockTimeout-1 while LOCKED and no release grant occurs that cycle: force UNLOCKED next cycle and pulse lock_timeout_o for one cycle.
  - The counter clears on every exit from LOCKED.
- Flush:
  - flush_i forces both readies to 0 that cycle and clears valid_q next cycle, regardless of issue_ack_i.
  - Flush also clears the lock and counter; last_q is unchanged.
- Simultaneous events:
  - flush_i with a valid handshake request: no transfer occurs.
  - Timeout cycle coinciding with a source-1 last-beat grant: normal release, no timeout pulse.
- Data passthrough: payload is never inspected or modified.
- Reset asserted mid-burst returns the block to UNLOCKED with an empty slot.

Test Plan:
- Tie fairness, both sources valid continuously with issue_ack_i=1 every cycle after reset -> grants alternate 0,1,0,1; issue_src_o sequence 0,1,0,1 with no bubbles.
- Burst lock, source 1 sends 3 beats (last=0,0,1) with src0 valid throughout -> src0_ready_o=0 during all 3 beats; locked_o high from the cycle after beat 1 until the cycle after beat 3; src0 granted next.
- Backpressure, slot full and issue_ack_i=0 for 4 cycles with both sources valid -> both readies 0; issue_data_o stable; on ack, the refill occurs in the same cycle.
- Timeout, LockTimeout=16, lock entered, then source 1 stalls valid low -> locked_o drops after 16 LOCKED cycles; lock_timeout_o pulses exactly once; src0 granted next cycle.
- Flush, flush_i asserted with the slot valid, locked, and src1 valid -> no ready; next cycle issue_valid_o=0 and locked_o=0; last_q preserved, so tie order continues.
- Mid-burst reset after beat 1 of a burst -> all outputs return to their reset values asynchronously; first tie after release goes to source 0.
